// File: rtl/demux_pkg.sv
// Shared encodings for the demux scheduler family: holding-stage state and
// destination-select modes.
package demux_pkg;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

endpackage

// File: rtl/demux_rr_ptr.sv
// Modulo-N_OUT round-robin pointer with synchronous clear (priority over
// increment) and asynchronous active-low reset.
module demux_rr_ptr #(
    parameter  int N_OUT = 4,
    localparam int SEL_W = $clog2(N_OUT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [SEL_W-1:0] ptr
);

    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;

    // N_OUT is a power of two, so the natural binary wrap is the modulo.
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + SEL_W'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/demux_1ton_sched.sv
// 1-to-N demultiplexer scheduler: single-entry holding register routing each
// accepted word to one channel chosen by explicit select or round-robin.
module demux_1ton_sched
    import demux_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int N_OUT  = 4,
    localparam int SEL_W  = $clog2(N_OUT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  in_sel,
    output logic [N_OUT-1:0]  out_valid,
    input  logic [N_OUT-1:0]  out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [SEL_W-1:0]  cur_ch,
    output logic [SEL_W-1:0]  rr_ptr
);

    state_e            state_q;
    state_e            state_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic [SEL_W-1:0]  ch_q;
    logic [SEL_W-1:0]  ch_d;
    logic              cur_ready_s;
    logic              accept_s;
    logic              deliver_s;
    logic              rr_inc_s;

    // Only the addressed consumer's ready matters; other bits are ignored.
    assign cur_ready_s = out_ready[ch_q];
    assign in_ready    = rst_n & ~flush & ((state_q == ST_EMPTY) | cur_ready_s);
    assign accept_s    = in_valid & in_ready;
    assign deliver_s   = (state_q == ST_FULL) & cur_ready_s;
    assign rr_inc_s    = accept_s & (mode == MODE_RR);

    demux_rr_ptr #(
        .N_OUT (N_OUT)
    ) u_rr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (rr_inc_s),
        .ptr   (rr_ptr)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: an accept on a delivering edge keeps the stage full.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else if (accept_s) begin
            state_d = ST_FULL;
        end else if (deliver_s) begin
            state_d = ST_EMPTY;
        end else begin
            state_d = state_q;
        end
    end

    // Holding-register load; mode is only sampled here.
    always_comb begin
        data_d = data_q;
        ch_d   = ch_q;
        if (accept_s) begin
            data_d = in_data;
            ch_d   = (mode == MODE_RR) ? rr_ptr : in_sel;
        end else begin
            data_d = data_q;
            ch_d   = ch_q;
        end
    end

    // Holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            ch_q   <= '0;
        end else begin
            data_q <= data_d;
            ch_q   <= ch_d;
        end
    end

    // One-hot valid decode from registered state and channel.
    always_comb begin
        out_valid = '0;
        case (state_q)
            ST_FULL:  out_valid[ch_q] = 1'b1;
            ST_EMPTY: out_valid = '0;
            default:  out_valid = '0;
        endcase
    end

    assign out_data = data_q;
    assign cur_ch   = ch_q;

endmodule
